// File: rtl/lsu.sv
// lsu: load/store unit issuing one req/ack data-memory transaction per instruction.
// Stalls the pipeline until the access completes; flags misaligned, illegal and timed-out ops.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        fault,
    output logic [31:0] fault_addr
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_sdata, r_wb_data, r_fault_addr;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd, r_wb_rd;
    logic [7:0]  r_cnt;
    logic        r_store, r_wb_valid, r_misalign, r_fault;
    logic        w_accept, w_illegal, w_misal, w_bad, w_req, w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata, w_wdata;
    logic [3:0]  w_be_st;

    assign w_accept  = (r_state == IDLE) & ex_valid & (ex_load | ex_store);
    // loads allow LB/LH/LW/LBU/LHU, stores only SB/SH/SW
    assign w_illegal = (ex_load & ex_store) |
                       (ex_load ? (funct3 == 3'b011 || funct3[2:1] == 2'b11) : (funct3[2] || funct3 == 3'b011));
    assign w_misal   = (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & |addr[1:0]);
    assign w_bad     = w_illegal | w_misal;
    assign w_req     = r_state == REQ;
    assign w_timeout = w_req & ~dmem_ack & (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    assign w_byte  = dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half  = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign w_ldata = r_f3[1] ? dmem_rdata :
                     r_f3[0] ? {{16{~r_f3[2] & w_half[15]}}, w_half} :
                               {{24{~r_f3[2] & w_byte[7]}}, w_byte};
    assign w_be_st = r_f3[1] ? 4'hF : r_f3[0] ? (r_addr[1] ? 4'hC : 4'h3) : 4'b0001 << r_addr[1:0];
    assign w_wdata = r_f3[1] ? r_sdata : r_f3[0] ? {2{r_sdata[15:0]}} : {4{r_sdata[7:0]}};

    // memory-side outputs are gated by REQ so they read 0 everywhere else
    assign stall      = w_accept | w_req;
    assign dmem_req   = w_req;
    assign dmem_we    = w_req & r_store;
    assign dmem_addr  = w_req ? {r_addr[31:2], 2'b00} : '0;
    assign dmem_be    = w_req ? (r_store ? w_be_st : 4'hF) : '0;
    assign dmem_wdata = (w_req & r_store) ? w_wdata : '0;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign misalign   = r_misalign;
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_bad ? DONE : REQ;
            REQ:     if (dmem_ack | w_timeout) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_sdata      <= '0;
            r_f3         <= '0;
            r_rd         <= '0;
            r_store      <= 1'b0;
            r_cnt        <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_misalign   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;
            if (w_accept) begin
                r_addr     <= addr;
                r_sdata    <= store_data;
                r_f3       <= funct3;
                r_rd       <= ex_rd;
                r_store    <= ex_store;
                r_cnt      <= '0;
                r_misalign <= ~w_illegal & w_misal;
                r_fault    <= w_illegal;
                if (w_bad) r_fault_addr <= addr;
            end
            if (w_req) begin
                r_cnt <= r_cnt + 8'd1;
                if (dmem_ack & ~r_store) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= w_ldata;
                    r_wb_rd    <= r_rd;
                end else if (w_timeout) begin
                    r_fault      <= 1'b1;
                    r_fault_addr <= r_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed-vector bench for lsu with hand-computed expectations.
// Uses TIMEOUT_CYCLES=4 so the timeout and late-ack boundaries are both reachable.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [4:0]  ex_rd;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign, fault;
    logic [31:0] fault_addr;
    int          n_vec = 0;
    int          n_bad = 0;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .ex_rd(ex_rd), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one instruction in IDLE, confirm the accept-cycle stall, then clear EX
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; funct3 = f3; addr = a; store_data = d; ex_rd = rd;
        #1;
        chk("accept_stall", stall, 1);
        chk("accept_noreq", dmem_req, 0);
        tick();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, a, 32'h0, rd);
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1;
        chk("ld_req", dmem_req, 1);
        chk("ld_addr", dmem_addr, {a[31:2], 2'b00});
        chk("ld_be", dmem_be, 4'hF);
        chk("ld_we", dmem_we, 0);
        chk("ld_req_stall", stall, 1);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_data", wb_data, exp);
        chk("ld_wb_rd", wb_rd, rd);
        chk("ld_done_stall", stall, 0);
        chk("ld_flags", {misalign, fault}, 0);
        tick();
        chk("ld_pulse_end", wb_valid, 0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic [3:0] be, input logic [31:0] wd);
        int nreq = 0;
        issue(1'b0, 1'b1, f3, a, d, 5'd0);
        for (int i = 0; i <= waits; i++) begin
            dmem_ack = (i == waits);
            #1;
            if (dmem_req) nreq++;
            chk("st_addr", dmem_addr, {a[31:2], 2'b00});
            chk("st_be", dmem_be, be);
            chk("st_wdata", dmem_wdata, wd);
            chk("st_we", dmem_we, 1);
            tick();
        end
        dmem_ack = 1'b0;
        #1;
        chk("st_req_cycles", nreq, waits + 1);
        chk("st_no_wb", wb_valid, 0);
        chk("st_done_stall", stall, 0);
        chk("st_done_req", dmem_req, 0);
        tick();
    endtask

    task automatic bad(input logic l, input logic s, input logic [2:0] f3, input logic [31:0] a,
                       input logic mis, input logic flt);
        issue(l, s, f3, a, 32'h0, 5'd1);
        #1;
        chk("bad_misalign", misalign, mis);
        chk("bad_fault", fault, flt);
        chk("bad_fault_addr", fault_addr, a);
        chk("bad_noreq", dmem_req, 0);
        chk("bad_stall", stall, 0);
        chk("bad_no_wb", wb_valid, 0);
        tick();
    endtask

    initial begin
        int nreq;
        rst_n = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; funct3 = '0;
        addr = '0; store_data = '0; ex_rd = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        #2;
        chk("rst_outs", {stall, dmem_req, dmem_we, dmem_be, wb_valid, misalign, fault}, 0);
        chk("rst_addr", dmem_addr | dmem_wdata | wb_data | fault_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
        #1;
        chk("nonmem_stall", stall, 0);
        ex_valid = 1'b0;
        tick();

        ld(3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        ld(3'b000, 32'h103, 5'd6, 32'h80FF1234, 32'hFFFFFF80);
        ld(3'b100, 32'h103, 5'd7, 32'h80FF1234, 32'h00000080);
        ld(3'b101, 32'h102, 5'd8, 32'h80FF1234, 32'h000080FF);
        ld(3'b001, 32'h102, 5'd9, 32'h80FF1234, 32'hFFFF80FF);
        ld(3'b001, 32'h100, 5'd10, 32'h80FF9234, 32'hFFFF9234);
        ld(3'b000, 32'h101, 5'd11, 32'h80FF1234, 32'h00000012);

        st(3'b000, 32'h201, 32'h000000AB, 3, 4'b0010, 32'hABABABAB);
        st(3'b001, 32'h202, 32'h1234CDEF, 0, 4'b1100, 32'hCDEFCDEF);
        st(3'b001, 32'h200, 32'h1234CDEF, 1, 4'b0011, 32'hCDEFCDEF);
        st(3'b010, 32'h300, 32'hCAFEF00D, 0, 4'b1111, 32'hCAFEF00D);

        bad(1'b0, 1'b1, 3'b010, 32'h302, 1'b1, 1'b0);
        bad(1'b1, 1'b0, 3'b011, 32'h400, 1'b0, 1'b1);
        bad(1'b1, 1'b1, 3'b010, 32'h404, 1'b0, 1'b1);
        bad(1'b0, 1'b1, 3'b100, 32'h408, 1'b0, 1'b1);
        bad(1'b1, 1'b0, 3'b101, 32'h40B, 1'b1, 1'b0);

        // never-acked load must give up after exactly 4 REQ cycles
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd3);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!dmem_req) break;
            nreq++;
            tick();
        end
        chk("to_req_cycles", nreq, 4);
        chk("to_fault", fault, 1);
        chk("to_fault_addr", fault_addr, 32'h500);
        chk("to_stall", stall, 0);
        chk("to_no_wb", wb_valid, 0);
        tick();

        issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd7);
        #1;
        chk("rr_req", dmem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_outs", {stall, dmem_req, dmem_we, dmem_be, wb_valid, misalign, fault}, 0);
        chk("rr_data", dmem_addr | dmem_wdata | wb_data | fault_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        ld(3'b010, 32'h104, 5'd9, 32'h11223344, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
